// File: rtl/decode_scoreboard.sv
// Decode-stage hazard/forwarding tracker: a DEPTH-entry shift scoreboard of issued
// destinations drives per-operand forward selects, a load-use stall and a stall counter.
module decode_scoreboard #(
    parameter int  DEPTH    = 2,
    parameter int  LOAD_LAT = 2,
    parameter int  CNT_W    = 16,
    localparam int FSEL_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [4:0]        dec_rs1,
    input  logic [4:0]        dec_rs2,
    input  logic              dec_use1,
    input  logic              dec_use2,
    input  logic [4:0]        dec_rd,
    input  logic              dec_wr,
    input  logic              dec_load,
    input  logic              hold,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic              dec_ready,
    output logic              stall,
    output logic [FSEL_W-1:0] fwd_sel1,
    output logic [FSEL_W-1:0] fwd_sel2,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic             v_q  [1:DEPTH];
    logic [4:0]       rd_q [1:DEPTH];
    logic             ld_q [1:DEPTH];
    logic             haz1;
    logic             haz2;
    logic             hazard;
    logic             issue_wr;
    logic [CNT_W-1:0] cnt_reg;

    generate
        if (LOAD_LAT > DEPTH) begin : g_bad_load_lat
            $error("decode_scoreboard: LOAD_LAT (%0d) exceeds DEPTH (%0d)", LOAD_LAT, DEPTH);
        end
    endgenerate

    // Scan oldest to youngest so the youngest matching producer overrides older ones.
    always_comb begin
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        haz1     = 1'b0;
        haz2     = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (dec_use1 && (dec_rs1 != 5'd0) && v_q[k] && (rd_q[k] == dec_rs1)) begin
                fwd_sel1 = FSEL_W'(k);
                haz1     = ld_q[k] && (k < LOAD_LAT);
            end
            if (dec_use2 && (dec_rs2 != 5'd0) && v_q[k] && (rd_q[k] == dec_rs2)) begin
                fwd_sel2 = FSEL_W'(k);
                haz2     = ld_q[k] && (k < LOAD_LAT);
            end
        end
    end

    assign hazard    = haz1 | haz2;
    assign stall     = dec_valid & (hazard | hold);
    assign dec_ready = dec_valid & ~hazard & ~hold & ~flush;
    assign issue_wr  = dec_ready & dec_wr & (dec_rd != 5'd0);

    genvar gi;
    generate
        for (gi = 1; gi <= DEPTH; gi++) begin : g_entry
            logic       v_reg;
            logic [4:0] rd_reg;
            logic       ld_reg;
            logic       v_next;
            logic [4:0] rd_next;
            logic       ld_next;

            if (gi == 1) begin : g_head
                assign v_next  = issue_wr;
                assign rd_next = dec_rd;
                assign ld_next = dec_load;
            end else begin : g_tail
                assign v_next  = v_q[gi-1];
                assign rd_next = rd_q[gi-1];
                assign ld_next = ld_q[gi-1];
            end

            // rd/ld need no reset: they are only ever observed through v.
            always_ff @(posedge clk) begin
                if (!rst || flush) begin
                    v_reg <= 1'b0;
                end else if (!hold) begin
                    v_reg <= v_next;
                end
                if (!hold) begin
                    rd_reg <= rd_next;
                    ld_reg <= ld_next;
                end
            end

            assign v_q[gi]  = v_reg;
            assign rd_q[gi] = rd_reg;
            assign ld_q[gi] = ld_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (cnt_clr) begin
            cnt_reg <= '0;
        end else if (dec_valid && hazard && !flush && !hold && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt_reg;

endmodule
